// File: rtl/digit_mult_pkg.sv
// Shared definitions for the digit-serial multiplier.
//   state_e      : sequencer states (IDLE, RUN, DONE)
//   digit_count  : number of 2-bit digits in an N-bit operand
//   idx_width    : width of a digit index register, never below 1
package digit_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned digit_count(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned idx_width(input int unsigned d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/digit_mult_2x2.sv
// Combinational 2-bit x 2-bit unsigned digit multiplier.
//   a_i : multiplicand digit
//   b_i : multiplier digit
//   p_o : 4-bit product
module digit_mult_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic [1:0] row0;
    logic [1:0] row1;

    // Two AND rows, the second weighted by 2, summed into four bits.
    assign row0 = a_i & {2{b_i[0]}};
    assign row1 = a_i & {2{b_i[1]}};
    assign p_o  = {2'b00, row0} + {1'b0, row1, 1'b0};

endmodule

// File: rtl/digit_serial_mult.sv
// Sequential unsigned N x N multiplier built on a single 2x2 digit core.
// One digit product per cycle is shifted to its weight and accumulated
// into a 2N-bit register; the result is offered on a valid/ready port.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   x, y                : N-bit unsigned operands
//   out_valid/out_ready : result handshake (valid only in DONE)
//   p                   : 2N-bit product, held stable while valid
//   busy                : high while digit products are being formed
// Optional build macro: DIGIT_MULT_ZERO_SKIP_EN -- a zero operand skips the
// digit loop and jumps straight to DONE with a zero product.
module digit_serial_mult
    import digit_mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p,
    output logic             busy
);

    localparam int unsigned D  = digit_count(N);
    localparam int unsigned IW = idx_width(D);
    localparam int unsigned PW = 2 * N;
    // Largest shift is 2*(2D-2) = 2N-4, which fits in clog2(2N)+1 bits.
    localparam int unsigned SW = $clog2(PW) + 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    xr_q, xr_d;
    logic [N-1:0]    yr_q, yr_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;

    logic [1:0]      xdig;
    logic [1:0]      ydig;
    logic [3:0]      pp;
    logic [SW-1:0]   shamt;
    logic [PW-1:0]   pp_ext;

    // Digit-select muxes feeding the shared 2x2 core.
    always_comb begin
        xdig = '0;
        ydig = '0;
        for (int k = 0; k < int'(D); k++) begin
            if (i_q == IW'(k)) xdig = xr_q[2*k +: 2];
            if (j_q == IW'(k)) ydig = yr_q[2*k +: 2];
        end
    end

    digit_mult_2x2 u_core (
        .a_i (xdig),
        .b_i (ydig),
        .p_o (pp)
    );

    // Digit product weight is 4^(i+j): zero-extend, then shift by 2(i+j).
    assign shamt  = SW'({i_q, 1'b0}) + SW'({j_q, 1'b0});
    assign pp_ext = PW'(pp) << shamt;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
`ifdef DIGIT_MULT_ZERO_SKIP_EN
                    // Zero operand: product is already known, enter DONE on
                    // the acceptance edge with the cleared accumulator.
                    if ((x == '0) || (y == '0)) state_d = DONE;
`endif
                end
            end
            RUN: begin
                acc_d = acc_q + pp_ext;
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                    if (i_q == LAST) state_d = DONE;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign p         = acc_q;

endmodule

// File: tb/tb_digit_serial_mult.sv
// Scoreboard bench for digit_serial_mult at N=8 (directed) and N=4/N=2
// (exhaustive). Stimulus pushes expected results; monitors pop and compare.
module tb_digit_serial_mult;

    typedef struct {
        logic [15:0] p;
        int          lat;
        int          hold;
        int          bsy;
    } exp_t;

`ifdef DIGIT_MULT_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, bz8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;
    logic        iv4, ir4, ov4, bz4;
    logic [3:0]  x4, y4;
    logic [7:0]  p4;
    logic        iv2, ir2, ov2, bz2;
    logic [1:0]  x2, y2;
    logic [3:0]  p2;

    digit_serial_mult #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
        .out_valid(ov8), .out_ready(or8), .p(p8), .busy(bz8)
    );
    digit_serial_mult #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .x(x4), .y(y4),
        .out_valid(ov4), .out_ready(1'b1), .p(p4), .busy(bz4)
    );
    digit_serial_mult #(.N(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .x(x2), .y(y2),
        .out_valid(ov2), .out_ready(1'b1), .p(p2), .busy(bz2)
    );

    exp_t q8[$];
    exp_t q4[$];
    exp_t q2[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int exp_lat(input int d2, input bit zero);
        return (ZS && zero) ? 0 : d2;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // N=8 monitor: latency, busy length, hold length and p stability.
    int acc8 = 0, hs8 = 0, v8 = 0, b8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            v8 = 0;
            b8 = 0;
        end else begin
            if (bz8) b8++;
            if (ov8) begin
                if (q8.size() == 0) begin
                    chk("n8_unexpected_valid", 32'(ov8), 32'(0));
                end else begin
                    e = q8[0];
                    if (v8 == 0) chk("n8_latency", cyc - acc8, e.lat);
                    chk("n8_p", 32'(p8), 32'(e.p));
                    v8++;
                    if (or8) begin
                        chk("n8_hold", v8, e.hold);
                        chk("n8_busy_cycles", b8, e.bsy);
                        void'(q8.pop_front());
                        v8  = 0;
                        b8  = 0;
                        hs8 = cyc + 1;
                    end
                end
            end
            if (iv8 && ir8) begin
                acc8 = cyc + 1;
                b8   = 0;
            end
        end
    end

    // N=4 monitor (out_ready tied high).
    int acc4 = 0, b4 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            b4 = 0;
        end else begin
            if (bz4) b4++;
            if (ov4) begin
                if (q4.size() == 0) begin
                    chk("n4_unexpected_valid", 32'(ov4), 32'(0));
                end else begin
                    e = q4.pop_front();
                    chk("n4_p", 32'(p4), 32'(e.p));
                    chk("n4_latency", cyc - acc4, e.lat);
                    chk("n4_busy_cycles", b4, e.bsy);
                    b4 = 0;
                end
            end
            if (iv4 && ir4) begin
                acc4 = cyc + 1;
                b4   = 0;
            end
        end
    end

    // N=2 monitor (out_ready tied high).
    int acc2 = 0, b2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            b2 = 0;
        end else begin
            if (bz2) b2++;
            if (ov2) begin
                if (q2.size() == 0) begin
                    chk("n2_unexpected_valid", 32'(ov2), 32'(0));
                end else begin
                    e = q2.pop_front();
                    chk("n2_p", 32'(p2), 32'(e.p));
                    chk("n2_latency", cyc - acc2, e.lat);
                    chk("n2_busy_cycles", b2, e.bsy);
                    b2 = 0;
                end
            end
            if (iv2 && ir2) begin
                acc2 = cyc + 1;
                b2   = 0;
            end
        end
    end

    // Present one N=8 pair, wait for acceptance, then scramble x/y.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit push,
                         input int hold, input logic [15:0] exp_p);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        iv8 = 1'b1;
        x8  = a;
        y8  = b;
        k   = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ir8 && k < 300);
        if (!ir8) chk("n8_accept_timeout", 32'(ir8), 32'(1));
        if (push) begin
            e.p    = exp_p;
            e.lat  = exp_lat(16, (a == 8'd0) || (b == 8'd0));
            e.hold = hold;
            e.bsy  = e.lat;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        x8  = ~a;
        y8  = ~b;
    endtask

    // Present one pair to the N=2 or N=4 instance, expected value x*y.
    task automatic send_s(input int w, input int a, input int b);
        exp_t e;
        int   k;
        logic rdy;
        @(posedge clk); #1;
        if (w == 2) begin
            iv2 = 1'b1; x2 = 2'(a); y2 = 2'(b);
        end else begin
            iv4 = 1'b1; x4 = 4'(a); y4 = 4'(b);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            rdy = (w == 2) ? ir2 : ir4;
        end while (!rdy && k < 300);
        if (!rdy) chk("small_accept_timeout", 32'(rdy), 32'(1));
        e.p    = 16'(a * b);
        e.lat  = exp_lat((w / 2) * (w / 2), (a == 0) || (b == 0));
        e.hold = 1;
        e.bsy  = e.lat;
        if (w == 2) q2.push_back(e);
        else        q4.push_back(e);
        @(posedge clk); #1;
        iv2 = 1'b0;
        iv4 = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q8.size() + q4.size() + q2.size()) != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_queues_empty", 32'(q8.size() + q4.size() + q2.size()), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        iv8 = 1'b0; x8 = '0; y8 = '0; or8 = 1'b1;
        iv4 = 1'b0; x4 = '0; y4 = '0;
        iv2 = 1'b0; x2 = '0; y2 = '0;
        rst = 1'b1;

        // Reset state, during and after reset.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir8), 32'(1));
        chk("rst_out_valid", 32'(ov8), 32'(0));
        chk("rst_busy", 32'(bz8), 32'(0));
        chk("rst_p", 32'(p8), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(ir8), 32'(1));
        chk("idle_out_valid", 32'(ov8), 32'(0));
        chk("idle_p", 32'(p8), 32'(0));

        // Abort mid-RUN: reset must clear outputs immediately.
        send8(8'h55, 8'h33, 1'b0, 1, 16'h0000);
        repeat (4) @(posedge clk);
        #1 chk("abort_busy_before", 32'(bz8), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(ir8), 32'(1));
        chk("abort_out_valid", 32'(ov8), 32'(0));
        chk("abort_busy", 32'(bz8), 32'(0));
        chk("abort_p", 32'(p8), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (25) @(posedge clk);

        // 0xFF * 0xFF with the consumer three cycles late.
        or8 = 1'b0;
        send8(8'hFF, 8'hFF, 1'b1, 4, 16'hFE01);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ov8 && k < 100);
        chk("late_valid_seen", 32'(ov8), 32'(1));
        repeat (3) @(posedge clk);
        #1 or8 = 1'b1;
        @(posedge clk); #1;
        chk("late_back_to_idle", 32'(ir8), 32'(1));
        chk("late_valid_dropped", 32'(ov8), 32'(0));

        // Back-to-back with out_ready held high.
        send8(8'd13, 8'd11, 1'b1, 1, 16'd143);
        send8(8'd200, 8'd3, 1'b1, 1, 16'd600);
        chk("b2b_first_idle_accept", acc8 - hs8, 1);

        // Operands offered during RUN must be ignored.
        send8(8'd7, 8'd9, 1'b1, 1, 16'd63);
        repeat (2) @(posedge clk);
        #1 iv8 = 1'b1; x8 = 8'd5; y8 = 8'd5;
        repeat (5) @(posedge clk);
        #1 iv8 = 1'b0;

        // Zero operand and a few more hand-computed products.
        send8(8'h00, 8'hA5, 1'b1, 1, 16'h0000);
        send8(8'hA5, 8'h5A, 1'b1, 1, 16'd14850);
        send8(8'h80, 8'h80, 1'b1, 1, 16'h4000);
        send8(8'h01, 8'hFF, 1'b1, 1, 16'h00FF);
        wait_drain();

        // Exhaustive sweeps at N=2 and N=4.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                send_s(2, a, b);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                send_s(4, a, b);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
